mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. Sits in the EX stage next to the ALU.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It is the source of the multi-cycle stall request that the hazard unit merges into StallF, StallD and FlushE.
- While an operation runs in the background, it holds off any dependent MFHI, MFLO or multiply/divide instruction in Decode.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- CNT_WIDTH, 6, iteration counter width. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- i_clk, input, 1, clock; all state updates on rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_MDOpE, input, 3, op in EX: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- i_SrcAE, input, DATA_WIDTH, rs value (forwarded).
- i_SrcBE, input, DATA_WIDTH, rt value (forwarded).
- i_MDUseD, input, 1, Decode instruction is MFHI, MFLO, MTHI, MTLO, MULT(U) or DIV(U).
- o_StallReqD, output, 1, combinational stall request to the hazard unit.
- o_BusyE, output, 1, registered; operation in progress.
- o_DoneE, output, 1, registered one-cycle pulse when HI/LO are updated by mult/div.
- o_HI, output, DATA_WIDTH, HI register.
- o_LO, output, DATA_WIDTH, LO register.

Behaviour:
- Reset values: HI=0, LO=0, o_BusyE=0, o_DoneE=0, state=IDLE, counter=0. Reset at any point, including mid-operation, aborts the operation with no HI/LO write.
- States:
  - IDLE: MULT/MULTU/DIV/DIVU in i_MDOpE (accept cycle t) latches the operand magnitudes, result-sign flags and op, clears the partial product or remainder, counter=0, then goes to CALC. MTHI/MTLO write HI or LO from i_SrcAE at the edge; no busy; stay in IDLE.
  - CALC: one radix-2 step per cycle. Multiply is shift-add on unsigned magnitudes into a 2*DATA_WIDTH accumulator. Divide is restoring, one quotient bit per cycle. Counter increments; when counter==DATA_WIDTH-1, go to FINISH.
  - FINISH: apply sign correction, write HI/LO, pulse o_DoneE, return to IDLE.
- Latency and stalls:
  - o_BusyE is high from t+1 through the FINISH cycle (t+DATA_WIDTH+1) inclusive.
  - New HI/LO are visible at t+DATA_WIDTH+2 (t+34 for 32-bit).
  - i_MDOpE is ignored while state != IDLE. The stall guarantees no valid op arrives then.
  - o_StallReqD = i_MDUseD && (state != IDLE || i_MDOpE is MULT/MULTU/DIV/DIVU). The accept-cycle term covers back-to-back dependents.
- Signed rules:
  - Multiply: product sign = A[msb]^B[msb]; result is a two's-complement negation of the 64-bit magnitude product.
  - Divide: LO=quotient, HI=remainder. Quotient sign = A^B; remainder sign = A (truncating division).
- Boundary cases:
  - Overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0 (falls out of the magnitude method, no special case).
  - Divide by zero, signed or unsigned: LO=all ones, HI=dividend, taking the normal full latency.
- Simultaneous events: an MTHI/MTLO arriving while busy is impossible by the stall. If forced in a bench, it is ignored.

Optional Feature:
- MIPS_MULDIV_DIV_EN defined: DIV/DIVU supported as above.
- Undefined: the divider datapath is not built. DIV/DIVU are treated as no-ops: no busy, no stall contribution from the EX term, HI/LO unchanged. Multiply and MTHI/MTLO are unaffected.

Decomposition:
- Package mips_muldiv_pkg holds:
  - op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - state encodings (IDLE, CALC, FINISH);
  - a DEFAULT_DATA_WIDTH constant.
- One sub-module, mips_div_step: the combinational restoring-divide step (shift, trial subtract, quotient bit). It is instantiated only under MIPS_MULDIV_DIV_EN.
- The top module owns the FSM, counter, accumulator and HI/LO.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; o_DoneE pulses exactly once at FINISH.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; o_BusyE high for exactly 33 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT at t with i_MDUseD=1 at t (MFLO behind it) -> o_StallReqD high at t and through FINISH, low the next cycle; subsequent LO read returns the product.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in IDLE -> HI/LO update on the next edge; o_BusyE and o_StallReqD stay 0.
- MULT started, i_rst asserted at cycle t+10 -> next cycle state=IDLE, HI=LO=0, o_BusyE=0; no o_DoneE pulse.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS HI/LO multiply/divide unit.
package mips_muldiv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } md_state_e;

endpackage

// File: rtl/mips_muldiv_unit_div_step.sv
// One restoring-divide iteration: shift in a dividend bit, trial subtract,
// keep the difference when it does not borrow.
module mips_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted  = {rem, quo[W-1]};
        diff     = shifted - {1'b0, divisor};
        quo_next = {quo[W-2:0], ~diff[W]};
        rem_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO and the EX stall request.
// Define MIPS_MULDIV_DIV_EN to build the DIV/DIVU restoring divider.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2:0]            i_MDOpE,
    input  logic [DATA_WIDTH-1:0] i_SrcAE,
    input  logic [DATA_WIDTH-1:0] i_SrcBE,
    input  logic                  i_MDUseD,
    output logic                  o_StallReqD,
    output logic                  o_BusyE,
    output logic                  o_DoneE,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

    md_state_e            state;
    logic [CNT_WIDTH-1:0] count;
    logic [2*W-1:0]       acc;
    logic [W-1:0]         operand;
    logic                 neg_lo;

    logic                 mul_op;
    logic                 div_op;
    logic                 start;
    logic                 signed_op;
    logic                 sign_a;
    logic                 sign_b;
    logic [W-1:0]         mag_a;
    logic [W-1:0]         mag_b;
    logic [W:0]           add_sum;
    logic [2*W-1:0]       step_acc;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         res_hi;
    logic [W-1:0]         res_lo;

    assign mul_op = (i_MDOpE == MD_MULT) || (i_MDOpE == MD_MULTU);
`ifdef MIPS_MULDIV_DIV_EN
    assign div_op = (i_MDOpE == MD_DIV) || (i_MDOpE == MD_DIVU);
`else
    assign div_op = 1'b0;
`endif
    assign start     = mul_op || div_op;
    assign signed_op = (i_MDOpE == MD_MULT) || (i_MDOpE == MD_DIV);
    assign sign_a    = signed_op & i_SrcAE[W-1];
    assign sign_b    = signed_op & i_SrcBE[W-1];
    assign mag_a     = sign_a ? -i_SrcAE : i_SrcAE;
    assign mag_b     = sign_b ? -i_SrcBE : i_SrcBE;

    assign o_StallReqD = i_MDUseD && ((state != IDLE) || start);

`ifdef MIPS_MULDIV_DIV_EN
    logic         div_mode;
    logic         neg_hi;
    logic [W-1:0] rem_next;
    logic [W-1:0] quo_next;

    mips_div_step #(.W(W)) u_div_step (
        .rem      (acc[2*W-1:W]),
        .quo      (acc[W-1:0]),
        .divisor  (operand),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );
`endif

    // Multiply keeps the multiplier in acc's low half and shifts it out
    // as the partial product moves in from the top.
    always_comb begin
        add_sum  = {1'b0, acc[2*W-1:W]}
                 + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
        step_acc = {add_sum, acc[W-1:1]};
        prod     = neg_lo ? -acc : acc;
        res_hi   = prod[2*W-1:W];
        res_lo   = prod[W-1:0];
`ifdef MIPS_MULDIV_DIV_EN
        if (div_mode) begin
            step_acc = {rem_next, quo_next};
            res_lo   = neg_lo ? -acc[W-1:0] : acc[W-1:0];
            res_hi   = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            neg_lo  <= 1'b0;
            o_HI    <= '0;
            o_LO    <= '0;
            o_BusyE <= 1'b0;
            o_DoneE <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
            div_mode <= 1'b0;
            neg_hi   <= 1'b0;
`endif
        end else begin
            o_DoneE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CALC;
                        o_BusyE <= 1'b1;
                        count   <= '0;
                        acc     <= {{W{1'b0}}, div_op ? mag_a : mag_b};
                        operand <= div_op ? mag_b : mag_a;
                        // A zero divisor must leave an all-ones quotient.
                        neg_lo  <= (sign_a ^ sign_b)
                                 & (~div_op | (|i_SrcBE));
`ifdef MIPS_MULDIV_DIV_EN
                        div_mode <= div_op;
                        neg_hi   <= sign_a;
`endif
                    end else if (i_MDOpE == MD_MTHI) begin
                        o_HI <= i_SrcAE;
                    end else if (i_MDOpE == MD_MTLO) begin
                        o_LO <= i_SrcAE;
                    end
                end
                CALC: begin
                    acc   <= step_acc;
                    count <= count + 1'b1;
                    if (count == LAST) state <= FINISH;
                end
                FINISH: begin
                    o_HI    <= res_hi;
                    o_LO    <= res_lo;
                    o_DoneE <= 1'b1;
                    o_BusyE <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized bench for mips_muldiv_unit against an arithmetic HI/LO model.
// Honours MIPS_MULDIV_DIV_EN the same way as the design.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

`ifdef MIPS_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    mips_muldiv_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_MDOpE     (op),
        .i_SrcAE     (a),
        .i_SrcBE     (b),
        .i_MDUseD    (use_d),
        .o_StallReqD (stall),
        .o_BusyE     (busy),
        .o_DoneE     (done),
        .o_HI        (hi),
        .o_LO        (lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Architectural result of one op, straight from the MIPS definition.
    task automatic model_op(input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint          p;
        longint unsigned pu;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            MD_MULT: begin
                p = sx * sy;
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            MD_MULTU: begin
                pu = {32'd0, x} * {32'd0, y};
                hi_m = pu[63:32];
                lo_m = pu[31:0];
            end
            MD_DIV: if (DIV_EN) begin
                if (y == 0) begin
                    lo_m = '1;
                    hi_m = x;
                end else begin
                    p = sx / sy;
                    lo_m = p[31:0];
                    p = sx % sy;
                    hi_m = p[31:0];
                end
            end
            MD_DIVU: if (DIV_EN) begin
                if (y == 0) begin
                    lo_m = '1;
                    hi_m = x;
                end else begin
                    lo_m = x / y;
                    hi_m = x % y;
                end
            end
            MD_MTHI: hi_m = x;
            MD_MTLO: lo_m = x;
            default: ;
        endcase
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic u,
                       input string tag);
        bit starts;
        bit is_mt;
        int busy_n = 0;
        int done_n = 0;
        int done_at = 0;
        int stall_n = 0;
        starts = (o == MD_MULT) || (o == MD_MULTU)
               || (DIV_EN && ((o == MD_DIV) || (o == MD_DIVU)));
        is_mt  = (o == MD_MTHI) || (o == MD_MTLO);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        use_d = u;
        #1;
        check({tag, ":stall_t"}, 64'(stall), 64'(u && starts));
        model_op(o, x, y);
        @(negedge clk);
        for (int k = 1; k <= 36; k++) begin
            op = MD_NONE;
            a = $urandom;
            b = $urandom;
            #1;
            if (busy) busy_n++;
            if (stall) stall_n++;
            if (done) begin
                done_n++;
                done_at = k;
            end
            if (k == 34 || (is_mt && k == 1)) begin
                check({tag, ":hi"}, 64'(hi), 64'(hi_m));
                check({tag, ":lo"}, 64'(lo), 64'(lo_m));
            end
            @(negedge clk);
        end
        check({tag, ":busy_cycles"}, 64'(busy_n), starts ? 64'd33 : 64'd0);
        check({tag, ":done_count"}, 64'(done_n), starts ? 64'd1 : 64'd0);
        check({tag, ":done_at"}, 64'(done_at), starts ? 64'd34 : 64'd0);
        check({tag, ":stall_cycles"}, 64'(stall_n),
              (starts && u) ? 64'd33 : 64'd0);
    endtask

    task automatic reset_mid_op();
        int done_n = 0;
        int busy_n = 0;
        @(negedge clk);
        op = MD_MULT;
        a = 32'h0000_1234;
        b = 32'h0000_5678;
        use_d = 1'b1;
        @(negedge clk);
        op = MD_NONE;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid:busy", 64'(busy), 64'd0);
        check("rst_mid:idle", 64'(stall), 64'd0);
        check("rst_mid:hi", 64'(hi), 64'd0);
        check("rst_mid:lo", 64'(lo), 64'd0);
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done) done_n++;
            if (busy) busy_n++;
        end
        check("rst_mid:no_done", 64'(done_n), 64'd0);
        check("rst_mid:no_busy", 64'(busy_n), 64'd0);
        check("rst_mid:hi_after", 64'(hi), 64'd0);
        use_d = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        op = MD_NONE;
        a = '0;
        b = '0;
        use_d = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset:hi", 64'(hi), 64'd0);
        check("reset:lo", 64'(lo), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:done", 64'(done), 64'd0);
        check("reset:stall", 64'(stall), 64'd0);
        rst = 1'b0;

        run(MD_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0, "mult_neg");
        run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, "div_neg");
        run(MD_DIVU,  32'd7,         32'd0,         1'b1, "divu_zero");
        run(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run(MD_DIV,   32'hFFFF_FFF0, 32'd0,         1'b0, "div_zero_neg");
        run(MD_MULT,  32'h0001_2345, 32'hFFFF_0006, 1'b1, "mult_stall");
        run(MD_MTHI,  32'h1234_5678, 32'd0,         1'b1, "mthi");
        run(MD_MTLO,  32'h9ABC_DEF0, 32'd0,         1'b1, "mtlo");

        reset_mid_op();

        for (int i = 0; i < 30; i++) begin
            run(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
